ldpc_info_blk_loader: RTL and testbench
=======================================

// Module: ldpc_info_blk_loader
// PURPOSE
//  Upstream stage of the QC-LDPC encoder. Collects NUM_INFO_BLKS info blocks of the selected Z
//  from a valid/ready source, then streams them to the encoder one block per beat.
//  Latches the requested lifting size once per frame and tags the stream with first/last
//  markers, so the encoder's column counter and ROM addressing stay frame-aligned.
// PARAMETERS
//  NUM_Z          3             number of supported lifting sizes (width of one-hot req_z)
//  MAX_Z          81            largest Z; width of every data path
//  NUM_INFO_BLKS  20            info blocks per code block (frame length in beats)
//  Z_VALUES       {27,54,81}    Z for each req_z bit; Z_VALUES[i] <= MAX_Z
// PORTS
//  CLK        in   1              clock, rising edge
//  rst_n      in   1              asynchronous active-low reset
//  req_z      in   NUM_Z          one-hot Z select, sampled only on a frame's first accepted beat
//  s_valid    in   1              source beat valid
//  s_ready    out  1              loader accepting beats
//  s_data     in   MAX_Z          info block, LSB-aligned, bits [Z-1:0] meaningful
//  m_valid    out  1              block to encoder valid
//  m_ready    in   1              encoder accepts block
//  m_data     out  MAX_Z          info block to encoder
//  m_first    out  1              qualifies m_data as info block 0
//  m_last     out  1              qualifies m_data as info block NUM_INFO_BLKS-1
//  m_z_sel    out  NUM_Z          latched one-hot Z for the frame being drained
//  busy       out  1              high in FILL or DRAIN
//  err_req_z  out  1              one-cycle pulse: first beat offered with non-one-hot req_z
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; wr_cnt=rd_cnt=0; all outputs 0, incl. s_ready.
//   s_ready is registered; it rises on the first CLK edge after rst_n deasserts.
//  Buffer: NUM_INFO_BLKS x MAX_Z register array; wr_cnt/rd_cnt are $clog2(NUM_INFO_BLKS) bits.
//  FSM:
//   IDLE : s_ready=1. Accepted beat (s_valid&s_ready) with $onehot(req_z): latch req_z into
//          m_z_sel, write buf[0], wr_cnt<=1, go FILL. Non-one-hot: beat dropped,
//          err_req_z=1 next cycle, stay IDLE.
//   FILL : s_ready=1; req_z ignored. Each accepted beat writes buf[wr_cnt], wr_cnt++.
//          Beat at wr_cnt==NUM_INFO_BLKS-1: s_ready<=0, rd_cnt<=0, go DRAIN.
//   DRAIN: s_ready=0; s_valid ignored. m_valid=1, m_data=buf[rd_cnt],
//          m_first=(rd_cnt==0), m_last=(rd_cnt==NUM_INFO_BLKS-1).
//          m_valid&m_ready: rd_cnt++. On the last block: m_valid<=0, s_ready<=1, go IDLE.
//  Latency: m_valid rises on the edge after the last input beat is accepted. Beat k of the output
//   is presented for >=1 cycle; throughput 1 block/cycle while m_ready=1.
//  Stall: m_valid&!m_ready holds m_data/m_first/m_last/m_z_sel stable (AXI-style; never retracted).
//  Frame gap: minimum 1 idle cycle on s_* between DRAIN end and next frame (s_ready re-registers).
//  All m_* outputs are registered; no combinational path from m_ready or s_valid to any output.
//  Reset mid-frame: partial fill/drain discarded; no m_last is emitted for that frame.
//  Mid-frame req_z change: ignored until the next IDLE acceptance.
// CONFIGURATION
//  `LDPC_LOADER_ZMASK_EN defined: on write, bits [MAX_Z-1:Z_sel] of s_data are forced to 0,
//   using the Z latched for the frame (beat 0 uses the req_z being latched).
//  Not defined: s_data is stored unmodified; the encoder is responsible for ignoring upper bits.
// TESTING
//  1 Reset: hold rst_n=0, drive s_valid=1 -> s_ready=m_valid=busy=0; s_ready=1 one edge after release.
//  2 Basic frame, req_z=3'b010 (Z=54), beats 0..19 = pattern k, m_ready=1 -> m_valid 1 cycle after
//    beat 19; 20 consecutive m_data=k; m_first on k=0; m_last on k=19; m_z_sel=3'b010.
//  3 Backpressure: m_ready toggles 1,0,0,1 during DRAIN -> m_data stable while stalled; order intact;
//    s_ready=0 throughout DRAIN, and a s_valid pulse during DRAIN is not stored.
//  4 Bad select: req_z=3'b011 on first beat -> err_req_z pulses once, state stays IDLE; the next beat
//    with req_z=3'b001 starts the frame.
//  5 ZMASK: with macro defined, req_z=3'b001 (Z=27), s_data all ones -> m_data=27'h7FFFFFF
//    zero-extended; without the macro -> m_data all 81 ones.
//  6 Reset mid-FILL after 7 beats, then a full new frame -> exactly 20 output beats, first m_data is the
//    new frame's beat 0.

Source files
------------

// File: rtl/ldpc_info_blk_loader_if.sv
// Source/encoder-side bundle of the QC-LDPC info block loader.
// "slave" is the loader's view; "master" drives the source side and sinks the encoder side.
interface ldpc_info_blk_loader_if #(
    parameter int NUM_Z = 3,
    parameter int MAX_Z = 81
);
    logic [NUM_Z-1:0] req_z;
    logic             s_valid;
    logic             s_ready;
    logic [MAX_Z-1:0] s_data;
    logic             m_valid;
    logic             m_ready;
    logic [MAX_Z-1:0] m_data;
    logic             m_first;
    logic             m_last;
    logic [NUM_Z-1:0] m_z_sel;
    logic             busy;
    logic             err_req_z;

    modport slave (
        input  req_z, s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_first, m_last, m_z_sel, busy, err_req_z
    );

    modport master (
        output req_z, s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_first, m_last, m_z_sel, busy, err_req_z
    );
endinterface

// File: rtl/ldpc_info_blk_loader.sv
// Collects NUM_INFO_BLKS info blocks per frame, then drains them to the LDPC encoder tagged first/last.
// Optional LDPC_LOADER_ZMASK_EN zeroes s_data bits at and above the frame's Z on write. Needs NUM_INFO_BLKS >= 2.
module ldpc_info_blk_loader #(
    parameter int                     NUM_Z         = 3,
    parameter int                     MAX_Z         = 81,
    parameter int                     NUM_INFO_BLKS = 20,
    parameter logic [NUM_Z-1:0][31:0] Z_VALUES      = {32'd81, 32'd54, 32'd27}
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    ldpc_info_blk_loader_if.slave       ld_io
);
    localparam int             CW   = $clog2(NUM_INFO_BLKS);
    localparam logic [CW-1:0]  LAST = CW'(NUM_INFO_BLKS - 1);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_e;

    for (genvar gi = 0; gi < NUM_Z; gi++) begin : g_zchk
        if (Z_VALUES[gi] == 0 || Z_VALUES[gi] > MAX_Z) begin : g_bad
            $error("Z_VALUES entry out of range 1..MAX_Z");
        end
    end

    state_e                                state_q;
    logic [CW-1:0]                         wr_cnt_q, rd_cnt_q, rd_nxt;
    logic [NUM_INFO_BLKS-1:0][MAX_Z-1:0]   blk_q;
    logic                                  s_ready_q, m_valid_q, m_first_q, m_last_q, err_q;
    logic [MAX_Z-1:0]                      m_data_q, wdata;
    logic [NUM_Z-1:0]                      m_z_sel_q;

    assign rd_nxt = rd_cnt_q + 1'b1;

`ifdef LDPC_LOADER_ZMASK_EN
    logic [NUM_Z-1:0] zsel;
    logic [MAX_Z-1:0] zmask;

    // Beat 0 is masked with the select being latched, later beats with the latched one.
    assign zsel = (state_q == IDLE) ? ld_io.req_z : m_z_sel_q;

    always_comb begin
        zmask = '0;
        for (int i = 0; i < NUM_Z; i++) begin
            if (zsel[i]) begin
                for (int j = 0; j < MAX_Z; j++) begin
                    if (j < int'(Z_VALUES[i])) zmask[j] = 1'b1;
                end
            end
        end
    end

    assign wdata = ld_io.s_data & zmask;
`else
    assign wdata = ld_io.s_data;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            blk_q     <= '0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_first_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_z_sel_q <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    s_ready_q <= 1'b1;
                    if (ld_io.s_valid && s_ready_q) begin
                        if ($onehot(ld_io.req_z)) begin
                            m_z_sel_q <= ld_io.req_z;
                            blk_q[0]  <= wdata;
                            wr_cnt_q  <= CW'(1);
                            state_q   <= FILL;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (ld_io.s_valid && s_ready_q) begin
                        blk_q[wr_cnt_q] <= wdata;
                        if (wr_cnt_q == LAST) begin
                            // Present block 0 on the very next cycle.
                            s_ready_q <= 1'b0;
                            wr_cnt_q  <= '0;
                            rd_cnt_q  <= '0;
                            m_valid_q <= 1'b1;
                            m_data_q  <= blk_q[0];
                            m_first_q <= 1'b1;
                            m_last_q  <= 1'b0;
                            state_q   <= DRAIN;
                        end else begin
                            wr_cnt_q <= wr_cnt_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (ld_io.m_ready) begin
                        if (rd_cnt_q == LAST) begin
                            m_valid_q <= 1'b0;
                            m_first_q <= 1'b0;
                            m_last_q  <= 1'b0;
                            s_ready_q <= 1'b1;
                            rd_cnt_q  <= '0;
                            state_q   <= IDLE;
                        end else begin
                            rd_cnt_q  <= rd_nxt;
                            m_data_q  <= blk_q[rd_nxt];
                            m_first_q <= 1'b0;
                            m_last_q  <= (rd_nxt == LAST);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ld_io.s_ready   = s_ready_q;
    assign ld_io.m_valid   = m_valid_q;
    assign ld_io.m_data    = m_data_q;
    assign ld_io.m_first   = m_first_q;
    assign ld_io.m_last    = m_last_q;
    assign ld_io.m_z_sel   = m_z_sel_q;
    assign ld_io.busy      = (state_q != IDLE);
    assign ld_io.err_req_z = err_q;
endmodule

// File: tb/tb_ldpc_info_blk_loader.sv
// Bench for ldpc_info_blk_loader: frame table + scoreboard, plus reset, bad-select and mid-fill reset sequences.
module tb_ldpc_info_blk_loader;
    localparam int NZ = 3;
    localparam int W  = 81;
    localparam int NB = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ldpc_info_blk_loader_if #(.NUM_Z(NZ), .MAX_Z(W)) bus ();

    ldpc_info_blk_loader #(.NUM_Z(NZ), .MAX_Z(W), .NUM_INFO_BLKS(NB)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .ld_io   (bus)
    );

    typedef struct {
        logic [W-1:0]  data;
        logic          first;
        logic          last;
        logic [NZ-1:0] zsel;
    } exp_t;

    typedef struct {
        logic [NZ-1:0] req_z;
        int            pat;
        int            rdy_mode;
        int            z;
        bit            poke;
        logic [NZ-1:0] exp_zsel;
    } vec_t;

    exp_t sb[$];
    exp_t held, e_mon;
    int   n_cmp = 0, n_bad = 0, n_out = 0, rdy_mode = 0, rcyc = 0;
    bit   stall_q = 1'b0;

    task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired or unexpected event", nm);
    endtask

    // Encoder-side ready: always on, 1,0,0,1 pattern, or random.
    always @(posedge clk) begin
        #1;
        rcyc++;
        case (rdy_mode)
            0:       bus.m_ready = 1'b1;
            1:       bus.m_ready = ((rcyc % 4) == 0) || ((rcyc % 4) == 3);
            default: bus.m_ready = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q && bus.m_valid) begin
                chk("stall_data", bus.m_data, held.data);
                chk("stall_flags", W'({bus.m_first, bus.m_last, bus.m_z_sel}),
                    W'({held.first, held.last, held.zsel}));
            end
            if (bus.m_valid) chk("s_ready_in_drain", W'(bus.s_ready), '0);
            if (bus.m_valid && bus.m_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    fail_now("unexpected_out_beat");
                end else begin
                    e_mon = sb.pop_front();
                    chk("m_data", bus.m_data, e_mon.data);
                    chk("m_first_last", W'({bus.m_first, bus.m_last}), W'({e_mon.first, e_mon.last}));
                    chk("m_z_sel", W'(bus.m_z_sel), W'(e_mon.zsel));
                end
            end
            stall_q = bus.m_valid && !bus.m_ready;
            held    = '{bus.m_data, bus.m_first, bus.m_last, bus.m_z_sel};
        end
    end

    function automatic logic [W-1:0] gen(int pat, int k);
        logic [W-1:0] r;
        case (pat)
            0:       r = W'(k);
            1:       r = '1;
            2:       r = W'({$urandom, $urandom, $urandom});
            default: r = W'(1) << (k * 4);
        endcase
        return r;
    endfunction

    // Offer one beat; returns #1 after the edge that accepted it.
    task automatic beat(logic [NZ-1:0] rz, logic [W-1:0] d);
        bit ok = 1'b0;
        bus.req_z   = rz;
        bus.s_data  = d;
        bus.s_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bus.s_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("beat_timeout");
    endtask

    task automatic send_frame(vec_t v);
        exp_t         e;
        logic [W-1:0] d;
        rdy_mode = v.rdy_mode;
        for (int k = 0; k < NB; k++) begin
            d = gen(v.pat, k);
`ifdef LDPC_LOADER_ZMASK_EN
            e.data = d & ('1 >> (W - v.z));
`else
            e.data = d;
`endif
            e.first = (k == 0);
            e.last  = (k == NB - 1);
            e.zsel  = v.exp_zsel;
            sb.push_back(e);
            if (k == NB - 1) chk("m_valid_early", W'(bus.m_valid), '0);
            // After beat 0 the select wobbles; the latched one must stick.
            beat((k == 0) ? v.req_z : ~v.req_z, d);
        end
        bus.s_valid = 1'b0;
        chk("m_valid_latency", W'(bus.m_valid), W'(1));
        chk("busy_drain", W'(bus.busy), W'(1));
        if (v.poke) begin
            @(posedge clk);
            #1;
            bus.s_valid = 1'b1;
            bus.s_data  = '1;
            bus.req_z   = 3'b001;
            repeat (2) @(posedge clk);
            #1;
            bus.s_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((sb.size() != 0 || bus.m_valid) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) fail_now("drain_timeout");
        @(posedge clk);
        #1;
        rdy_mode = 0;
    endtask

    vec_t vt[5];
    int   n0;

    initial begin
        vt[0] = '{3'b010, 0, 0, 54, 1'b0, 3'b010};  // basic k pattern, Z=54
        vt[1] = '{3'b100, 2, 1, 81, 1'b1, 3'b100};  // 1,0,0,1 backpressure + s_valid poke
        vt[2] = '{3'b001, 1, 0, 27, 1'b0, 3'b001};  // all ones, Z=27 masking case
        vt[3] = '{3'b010, 3, 2, 54, 1'b1, 3'b010};  // walking bits, random ready
        vt[4] = '{3'b100, 2, 2, 81, 1'b0, 3'b100};

        // Reset holds everything low even with a beat offered.
        bus.s_valid = 1'b1;
        bus.s_data  = '1;
        bus.req_z   = 3'b001;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", W'(bus.s_ready), '0);
        chk("rst_m_valid", W'(bus.m_valid), '0);
        chk("rst_busy", W'(bus.busy), '0);
        chk("rst_err", W'(bus.err_req_z), '0);
        bus.s_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("rel_s_ready_before_edge", W'(bus.s_ready), '0);
        @(posedge clk);
        #1;
        chk("rel_s_ready_after_edge", W'(bus.s_ready), W'(1));

        for (int i = 0; i < 5; i++) begin
            n0 = n_out;
            send_frame(vt[i]);
            wait_drain();
            chk("frame_beat_count", W'(n_out - n0), W'(NB));
            chk("idle_after_frame", W'(bus.busy), '0);
        end

        // Non-one-hot select on a first beat: dropped, one-cycle error pulse.
        beat(3'b011, W'(81'h5A5));
        bus.s_valid = 1'b0;
        chk("err_pulse", W'(bus.err_req_z), W'(1));
        chk("err_stays_idle", W'(bus.busy), '0);
        @(posedge clk);
        #1;
        chk("err_one_cycle", W'(bus.err_req_z), '0);
        n0 = n_out;
        send_frame('{3'b001, 0, 0, 27, 1'b0, 3'b001});
        wait_drain();
        chk("after_err_count", W'(n_out - n0), W'(NB));

        // Reset after 7 fill beats; the partial frame must vanish.
        for (int k = 0; k < 7; k++) beat((k == 0) ? 3'b100 : 3'b010, W'(100 + k));
        @(negedge clk);
        rst_n = 1'b0;
        bus.s_valid = 1'b0;
        #1;
        chk("midrst_m_valid", W'(bus.m_valid), '0);
        chk("midrst_busy", W'(bus.busy), '0);
        chk("midrst_s_ready", W'(bus.s_ready), '0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n0 = n_out;
        send_frame('{3'b010, 3, 1, 54, 1'b0, 3'b010});
        wait_drain();
        chk("midrst_new_frame_count", W'(n_out - n0), W'(NB));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
